pwm_ref_loader: RTL and testbench
=================================

// Module: pwm_ref_loader
// PURPOSE
//  Upstream feeder of the PWM core: accepts period/duty/dead_time from a controller over a valid/ready handshake.
//  - Sanitises the values, holds them in shadow registers, and applies them to the PWM only on the core's ovf_trigger.
//  - Duty is slew-limited: it moves at most step_max per PWM period, so the core never sees mid-period or abrupt changes.
// PARAMETERS
//  WIDTH       32   width of period, duty, dead_time, step_max
//  RST_PERIOD  10   period driven to the PWM while in reset (must be >= 2)
// PORTS
//  clk          in   1      system clock
//  reset        in   1      asynchronous, active-low reset (0 = reset)
//  s_valid      in   1      controller presents new reference
//  s_ready      out  1      loader can accept a reference
//  s_period     in   WIDTH  requested period
//  s_duty       in   WIDTH  requested duty
//  s_dead_time  in   WIDTH  requested dead time
//  step_max     in   WIDTH  max duty change per ovf; 0 = apply duty in one step
//  ovf_trigger  in   1      1-cycle pulse from PWM core at counter wrap
//  period       out  WIDTH  active period to PWM core
//  duty         out  WIDTH  active duty to PWM core
//  dead_time    out  WIDTH  active dead time to PWM core
//  busy         out  1      state != IDLE
//  clamp_flag   out  1      sticky: some accepted value was clamped; cleared by next unclamped accept
//  update_done  out  1      1-cycle pulse when active duty reaches target
// BEHAVIOUR
//  Reset (async, reset=0):
//   - period=RST_PERIOD; duty=0; dead_time=0; state=IDLE
//   - s_ready=0, busy=0, clamp_flag=0, update_done=0
//   - s_ready rises on the first clock after reset release.
//  Handshake:
//   - Transfer when s_valid & s_ready at posedge clk.
//   - s_ready=1 in IDLE and RAMP, 0 in PENDING and in reset.
//   - s_ready is registered, with no combinational path from s_valid.
//  Sanitise (applied at accept, into shadow registers):
//   - p = max(s_period, 2); d = min(s_duty, p); t = min(s_dead_time, p>>1)
//   - clamp_flag = any clamp occurred in this accept.
//  States:
//   - IDLE --accept--> PENDING
//   - PENDING --ovf--> RAMP, or IDLE if duty already equals target after that ovf
//   - RAMP --ovf & duty==target after step--> IDLE
//   - RAMP --accept--> PENDING (retarget)
//  On the ovf that leaves PENDING (registers update on the same edge):
//   - period<=p, dead_time<=t
//   - duty<=min(duty,p), then stepped once in the same cycle.
//  Duty step (each ovf in PENDING/RAMP):
//   - diff = target-duty, computed signed in WIDTH+1 bits.
//   - If step_max==0 or |diff| <= step_max: duty<=target; otherwise duty<=duty ± step_max.
//   - No wrap-around: the result always lies between the old duty and the target.
//  update_done pulses on the cycle after duty becomes target; busy falls on the same cycle.
//  Simultaneous events:
//   - accept & ovf in RAMP: the step uses the old target, the new shadow is captured, next state=PENDING.
//   - ovf in IDLE: ignored.
//   - ovf in PENDING with s_valid: no accept (s_ready=0).
//  Reset mid-ramp: all outputs return to reset values immediately; the shadow is discarded.
//  All arithmetic is unsigned WIDTH except diff. Outputs are registered, latency >= 1 ovf from accept.
// STRUCTURE
//  - Shared header pwm_defs.vh: state codes ST_IDLE=2'd0, ST_PENDING=2'd1, ST_RAMP=2'd2;
//    default PWM_WIDTH=32; minimum period constant PWM_MIN_PERIOD=2.
//  - One sub-module, pwm_duty_slew (combinational): cur, target, step_max -> next duty.
//    Instantiated once; handshake, FSM and sanitise logic stay in this module.
// TESTING
//  1. Hold reset=0 for 5 clk, then release -> period=10, duty=0, dead_time=0 during reset; s_ready=1 one clk after release.
//  2. step_max=0; accept p=10,d=4,t=1; pulse ovf -> period=10, duty=4, dead_time=1 on that edge; update_done one clk later; outputs unchanged before the ovf.
//  3. step_max=2; duty=0; accept d=7 -> duty 2,4,6,7 on 4 successive ovf; update_done after the 4th; busy high throughout.
//  4. Accept p=1,d=500,t=9 -> p=2, d=2, t=1; clamp_flag=1; next accept p=10,d=3,t=1 clears it.
//  5. Mid-ramp (duty=4 -> 8, step 2), accept d=0 in the same cycle as ovf -> duty=6 on that edge, then 4,2,0 on following ovf.
//  6. Assert reset=0 mid-ramp between ovf pulses -> outputs immediately 10/0/0, no update_done, state IDLE after release.

Source files
------------

// File: rtl/pwm_ref_loader_pkg.sv
// Shared definitions for the PWM reference loader.
//   PWM_WIDTH      : default data width of period/duty/dead_time/step_max
//   PWM_MIN_PERIOD : smallest period ever driven to the PWM core
//   state_t        : loader FSM state codes
package pwm_ref_loader_pkg;

  localparam int unsigned PWM_WIDTH      = 32;
  localparam int unsigned PWM_MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RAMP    = 2'd2
  } state_t;

endpackage : pwm_ref_loader_pkg

// File: rtl/pwm_duty_slew.sv
// Combinational duty slew limiter: moves cur toward target by at most step_max.
//   cur         in  WIDTH  present active duty
//   target      in  WIDTH  requested duty
//   step_max    in  WIDTH  largest allowed change; 0 = jump straight to target
//   next_duty_c out WIDTH  next duty, always between cur and target inclusive
module pwm_duty_slew
  import pwm_ref_loader_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] step_max,
  output logic [WIDTH-1:0] next_duty_c
);

  logic signed [WIDTH:0] diff;
  logic        [WIDTH:0] mag;

  // Signed difference one bit wider than the operands so it can never wrap.
  always_comb begin
    diff = $signed({1'b0, target}) - $signed({1'b0, cur});
    mag  = diff[WIDTH] ? (WIDTH+1)'(-diff) : (WIDTH+1)'(diff);
    if ((step_max == '0) || (mag <= {1'b0, step_max})) begin
      next_duty_c = target;
    end else if (diff[WIDTH]) begin
      // mag > step_max here, so cur - step_max stays above target.
      next_duty_c = cur - step_max;
    end else begin
      next_duty_c = cur + step_max;
    end
  end

endmodule : pwm_duty_slew

// File: rtl/pwm_ref_loader.sv
// PWM reference loader: accepts period/duty/dead_time over valid/ready,
// sanitises them into shadow registers and applies them on ovf_trigger,
// slewing duty by at most step_max per PWM period.
//   clk, reset                  clock, async active-low reset
//   s_valid/s_ready             reference handshake (s_ready registered)
//   s_period/s_duty/s_dead_time requested reference
//   step_max                    max duty change per ovf (0 = single step)
//   ovf_trigger                 counter-wrap pulse from the PWM core
//   period/duty/dead_time       active values to the PWM core
//   busy                        loader not idle
//   clamp_flag                  last accepted reference was clamped
//   update_done                 pulse one cycle after duty reaches target
module pwm_ref_loader
  import pwm_ref_loader_pkg::*;
#(
  parameter int unsigned WIDTH      = PWM_WIDTH,
  parameter int unsigned RST_PERIOD = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_period,
  input  logic [WIDTH-1:0] s_duty,
  input  logic [WIDTH-1:0] s_dead_time,
  input  logic [WIDTH-1:0] step_max,
  input  logic             ovf_trigger,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] dead_time,
  output logic             busy,
  output logic             clamp_flag,
  output logic             update_done
);

  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(PWM_MIN_PERIOD);
  localparam logic [WIDTH-1:0] RST_P = WIDTH'(RST_PERIOD);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] dead_q, dead_d;
  logic [WIDTH-1:0] sh_period_q, sh_period_d;
  logic [WIDTH-1:0] sh_duty_q, sh_duty_d;
  logic [WIDTH-1:0] sh_dead_q, sh_dead_d;
  logic             s_ready_q, s_ready_d;
  logic             busy_q, busy_d;
  logic             clamp_q, clamp_d;
  logic             done_arm_q, done_arm_d;
  logic             update_done_q, update_done_d;

  logic             accept;
  logic             stepping;
  logic             reach;
  logic [WIDTH-1:0] san_p, san_d, san_t, half_p;
  logic             san_clamp;
  logic [WIDTH-1:0] slew_cur, slew_next;

  // Handshake and step qualifiers.
  always_comb begin
    accept   = s_valid && s_ready_q;
    stepping = ovf_trigger && (state_q != ST_IDLE);
    // A retarget on the same ovf never counts as completion.
    reach    = stepping && (slew_next == sh_duty_q) && !accept;
  end

  // Sanitise the incoming reference.
  always_comb begin
    san_p     = (s_period < MIN_P) ? MIN_P : s_period;
    half_p    = san_p >> 1;
    san_d     = (s_duty > san_p) ? san_p : s_duty;
    san_t     = (s_dead_time > half_p) ? half_p : s_dead_time;
    san_clamp = (s_period < MIN_P) || (s_duty > san_p) || (s_dead_time > half_p);
  end

  // When the new period is applied, duty is first clipped to it, then stepped.
  always_comb begin
    if (state_q == ST_PENDING) begin
      slew_cur = (duty_q > sh_period_q) ? sh_period_q : duty_q;
    end else begin
      slew_cur = duty_q;
    end
  end

  pwm_duty_slew #(
    .WIDTH(WIDTH)
  ) u_slew (
    .cur        (slew_cur),
    .target     (sh_duty_q),
    .step_max   (step_max),
    .next_duty_c(slew_next)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (ovf_trigger) state_d = reach ? ST_IDLE : ST_RAMP;
      end
      ST_RAMP: begin
        if (accept)     state_d = ST_PENDING;
        else if (reach) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next values.
  always_comb begin
    period_d      = period_q;
    duty_d        = duty_q;
    dead_d        = dead_q;
    sh_period_d   = sh_period_q;
    sh_duty_d     = sh_duty_q;
    sh_dead_d     = sh_dead_q;
    clamp_d       = clamp_q;
    if (accept) begin
      sh_period_d = san_p;
      sh_duty_d   = san_d;
      sh_dead_d   = san_t;
      clamp_d     = san_clamp;
    end
    if (stepping) begin
      duty_d = slew_next;
      if (state_q == ST_PENDING) begin
        period_d = sh_period_q;
        dead_d   = sh_dead_q;
      end
    end
    s_ready_d     = (state_d != ST_PENDING);
    // Busy is held over the completion edge so it drops with update_done.
    busy_d        = (state_d != ST_IDLE) || reach;
    done_arm_d    = reach;
    update_done_d = done_arm_q;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q      <= RST_P;
      duty_q        <= '0;
      dead_q        <= '0;
      sh_period_q   <= RST_P;
      sh_duty_q     <= '0;
      sh_dead_q     <= '0;
      s_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
      clamp_q       <= 1'b0;
      done_arm_q    <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      period_q      <= period_d;
      duty_q        <= duty_d;
      dead_q        <= dead_d;
      sh_period_q   <= sh_period_d;
      sh_duty_q     <= sh_duty_d;
      sh_dead_q     <= sh_dead_d;
      s_ready_q     <= s_ready_d;
      busy_q        <= busy_d;
      clamp_q       <= clamp_d;
      done_arm_q    <= done_arm_d;
      update_done_q <= update_done_d;
    end
  end

  assign period      = period_q;
  assign duty        = duty_q;
  assign dead_time   = dead_q;
  assign s_ready     = s_ready_q;
  assign busy        = busy_q;
  assign clamp_flag  = clamp_q;
  assign update_done = update_done_q;

endmodule : pwm_ref_loader

// File: tb/tb_pwm_ref_loader.sv
// Directed table-driven bench for pwm_ref_loader.
module tb_pwm_ref_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_period, s_duty, s_dead_time, step_max;
  logic        ovf_trigger;
  logic [31:0] period, duty, dead_time;
  logic        busy, clamp_flag, update_done;

  int applied = 0;
  int miscompares = 0;

  typedef struct {
    logic        v;
    logic [31:0] p, d, t, stp;
    logic        ovf;
    logic [31:0] e_per, e_duty, e_dead;
    logic        e_rdy, e_busy, e_clamp, e_done;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pwm_ref_loader #(.WIDTH(32), .RST_PERIOD(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_period   (s_period),
    .s_duty     (s_duty),
    .s_dead_time(s_dead_time),
    .step_max   (step_max),
    .ovf_trigger(ovf_trigger),
    .period     (period),
    .duty       (duty),
    .dead_time  (dead_time),
    .busy       (busy),
    .clamp_flag (clamp_flag),
    .update_done(update_done)
  );

  task automatic add(input logic v, input int p, input int d, input int t, input int stp,
                     input logic ovf, input int ep, input int ed, input int et,
                     input logic er, input logic eb, input logic ec, input logic eu);
    vec_t x;
    x.v = v; x.p = 32'(p); x.d = 32'(d); x.t = 32'(t); x.stp = 32'(stp); x.ovf = ovf;
    x.e_per = 32'(ep); x.e_duty = 32'(ed); x.e_dead = 32'(et);
    x.e_rdy = er; x.e_busy = eb; x.e_clamp = ec; x.e_done = eu;
    vecs.push_back(x);
  endtask

  // Drive one cycle of inputs at the falling edge, return 1 after the rising edge.
  task automatic cycle(input logic v, input logic [31:0] p, input logic [31:0] d,
                       input logic [31:0] t, input logic [31:0] stp, input logic ovf);
    @(negedge clk);
    s_valid = v; s_period = p; s_duty = d; s_dead_time = t; step_max = stp; ovf_trigger = ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] ep, input logic [31:0] ed,
                       input logic [31:0] et, input logic er, input logic eb,
                       input logic ec, input logic eu);
    applied++;
    if (period !== ep || duty !== ed || dead_time !== et || s_ready !== er ||
        busy !== eb || clamp_flag !== ec || update_done !== eu) begin
      miscompares++;
      $display("FAIL %s: got per=%0d duty=%0d dead=%0d rdy=%b busy=%b clamp=%b done=%b, exp per=%0d duty=%0d dead=%0d rdy=%b busy=%b clamp=%b done=%b",
               name, period, duty, dead_time, s_ready, busy, clamp_flag, update_done,
               ep, ed, et, er, eb, ec, eu);
    end
  endtask

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_period = '0; s_duty = '0; s_dead_time = '0;
    step_max = '0; ovf_trigger = 1'b0;

    // Ramp 0 -> 7 with step 2.
    add(1, 10,   7, 1, 2, 0,  10, 0, 0, 0, 1, 0, 0);
    add(0,  0,   0, 0, 2, 1,  10, 2, 1, 1, 1, 0, 0);
    add(0,  0,   0, 0, 2, 1,  10, 4, 1, 1, 1, 0, 0);
    add(0,  0,   0, 0, 2, 1,  10, 6, 1, 1, 1, 0, 0);
    add(0,  0,   0, 0, 2, 1,  10, 7, 1, 1, 1, 0, 0);
    add(0,  0,   0, 0, 2, 0,  10, 7, 1, 1, 0, 0, 1);
    add(0,  0,   0, 0, 2, 0,  10, 7, 1, 1, 0, 0, 0);
    // Single-step apply, unchanged before ovf; ovf in IDLE ignored.
    add(1, 10,   4, 1, 0, 0,  10, 7, 1, 0, 1, 0, 0);
    add(0,  0,   0, 0, 0, 0,  10, 7, 1, 0, 1, 0, 0);
    add(0,  0,   0, 0, 0, 1,  10, 4, 1, 1, 1, 0, 0);
    add(0,  0,   0, 0, 0, 0,  10, 4, 1, 1, 0, 0, 1);
    add(0,  0,   0, 0, 0, 1,  10, 4, 1, 1, 0, 0, 0);
    // Clamping and clamp_flag clear.
    add(1,  1, 500, 9, 0, 0,  10, 4, 1, 0, 1, 1, 0);
    add(0,  0,   0, 0, 0, 1,   2, 2, 1, 1, 1, 1, 0);
    add(0,  0,   0, 0, 0, 0,   2, 2, 1, 1, 0, 1, 1);
    add(1, 10,   3, 1, 0, 0,   2, 2, 1, 0, 1, 0, 0);
    add(0,  0,   0, 0, 0, 1,  10, 3, 1, 1, 1, 0, 0);
    add(0,  0,   0, 0, 0, 0,  10, 3, 1, 1, 0, 0, 1);
    // Retarget coinciding with ovf mid-ramp; valid ignored while pending.
    add(1, 10,   2, 1, 0, 0,  10, 3, 1, 0, 1, 0, 0);
    add(0,  0,   0, 0, 0, 1,  10, 2, 1, 1, 1, 0, 0);
    add(0,  0,   0, 0, 0, 0,  10, 2, 1, 1, 0, 0, 1);
    add(1, 10,   8, 1, 2, 0,  10, 2, 1, 0, 1, 0, 0);
    add(0,  0,   0, 0, 2, 1,  10, 4, 1, 1, 1, 0, 0);
    add(1, 10,   0, 1, 2, 1,  10, 6, 1, 0, 1, 0, 0);
    add(1, 10,   9, 1, 2, 1,  10, 4, 1, 1, 1, 0, 0);
    add(0,  0,   0, 0, 2, 1,  10, 2, 1, 1, 1, 0, 0);
    add(0,  0,   0, 0, 2, 1,  10, 0, 1, 1, 1, 0, 0);
    add(0,  0,   0, 0, 2, 0,  10, 0, 1, 1, 0, 0, 1);
    add(0,  0,   0, 0, 2, 0,  10, 0, 1, 1, 0, 0, 0);

    // Reset held for 5 clocks, then released.
    repeat (5) @(posedge clk);
    #1;
    check("reset_hold", 32'd10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", 32'd10, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].v, vecs[i].p, vecs[i].d, vecs[i].t, vecs[i].stp, vecs[i].ovf);
      check($sformatf("vec%0d", i), vecs[i].e_per, vecs[i].e_duty, vecs[i].e_dead,
            vecs[i].e_rdy, vecs[i].e_busy, vecs[i].e_clamp, vecs[i].e_done);
    end

    // Reset asserted mid-ramp between ovf pulses.
    cycle(1'b1, 32'd10, 32'd8, 32'd1, 32'd2, 1'b0);
    check("r6_accept", 32'd10, 32'd0, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd2, 1'b1);
    check("r6_step1", 32'd10, 32'd2, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd2, 1'b1);
    check("r6_step2", 32'd10, 32'd4, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    ovf_trigger = 1'b0;
    reset = 1'b0;
    #1;
    check("r6_async_reset", 32'd10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("r6_reset_hold", 32'd10, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("r6_release", 32'd10, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd2, 1'b1);
    check("r6_idle_ovf", 32'd10, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd2, 1'b0);
    check("r6_no_done", 32'd10, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule : tb_pwm_ref_loader
